// File: rtl/crono_pkg.sv
// rtl/crono_pkg.sv - shared types and limits for the MM:SS stopwatch/timer core
package crono_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef logic [3:0] bcd_t;

    localparam bcd_t SEC_TENS_MAX = 4'd5;
    localparam bcd_t MIN_TENS_MAX = 4'd5;
    localparam bcd_t DIGIT_MAX    = 4'd9;

    function automatic logic preset_legal(input bcd_t m1, input bcd_t m0,
                                          input bcd_t s1, input bcd_t s0);
        return (m1 <= MIN_TENS_MAX) && (m0 <= DIGIT_MAX) &&
               (s1 <= SEC_TENS_MAX) && (s0 <= DIGIT_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_updown.sv
// rtl/bcd_digit_updown.sv - one BCD digit, wraps 0..MAX, with carry/borrow out
module bcd_digit_updown
    import crono_pkg::*;
#(
    parameter bcd_t MAX = DIGIT_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic ld,
    input  bcd_t ld_val,
    input  logic inc,
    input  logic dec,
    output bcd_t q,
    output logic carry,
    output logic borrow
);

    bcd_t q_q;
    bcd_t q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = 4'd0;
        end else if (ld) begin
            q_d = ld_val;
        end else if (inc) begin
            q_d = (q_q == MAX) ? 4'd0 : q_q + 4'd1;
        end else if (dec) begin
            q_d = (q_q == 4'd0) ? MAX : q_q - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= 4'd0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q      = q_q;
    assign carry  = inc && (q_q == MAX);
    assign borrow = dec && (q_q == 4'd0);

endmodule

// File: rtl/crono_bcd_counter.sv
// rtl/crono_bcd_counter.sv - MM:SS up/down BCD counter with 1 Hz prescaler and control FSM
module crono_bcd_counter
    import crono_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int PRE_W         = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       load,
    input  logic       mode_down,
    input  logic [3:0] load_m1,
    input  logic [3:0] load_m0,
    input  logic [3:0] load_s1,
    input  logic [3:0] load_s0,
    output logic [3:0] m1,
    output logic [3:0] m0,
    output logic [3:0] s1,
    output logic [3:0] s0,
    output logic       running,
    output logic       done
);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_SEC - 1);

    state_e           state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             dir_q, dir_d;

    logic tick, step_up, step_dn;
    logic all_zero, one_left, load_ok;
    logic hold, terminal, digit_ld;
    bcd_t m1_ld, m0_ld, s1_ld, s0_ld;
    logic s0_carry, s0_borrow, s1_carry, s1_borrow;
    logic m0_carry, m0_borrow, m1_carry, m1_borrow;

    assign tick     = (state_q == ST_RUN) && (pre_q == PRE_LAST);
    assign step_up  = tick && !dir_q;
    assign step_dn  = tick && dir_q;
    assign all_zero = ({m1, m0, s1, s0} == 16'h0000);
    assign one_left = ({m1, m0, s1, s0} == 16'h0001);
    assign load_ok  = load && !clear && (state_q == ST_IDLE) &&
                      preset_legal(load_m1, load_m0, load_s1, load_s0);

    // A ripple out of the top digit means 59:59 counting up; reloading the
    // current value keeps the display frozen instead of wrapping to 00:00.
    assign hold     = m1_carry || m1_borrow;
    assign terminal = hold || (step_dn && one_left);
    assign digit_ld = load_ok || hold;
    assign m1_ld    = load_ok ? load_m1 : m1;
    assign m0_ld    = load_ok ? load_m0 : m0;
    assign s1_ld    = load_ok ? load_s1 : s1;
    assign s0_ld    = load_ok ? load_s0 : s0;

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        dir_d   = dir_q;
        case (state_q)
            ST_IDLE: begin
                if (!clear && !load && start_stop && !(mode_down && all_zero)) begin
                    state_d = ST_RUN;
                    dir_d   = mode_down;
                    pre_d   = '0;
                end
            end
            ST_RUN: begin
                pre_d = tick ? '0 : pre_q + 1'b1;
                if (terminal) begin
                    state_d = ST_DONE;
                end else if (start_stop) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (start_stop) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (load_ok) begin
            pre_d = '0;
        end
        if (clear) begin
            state_d = ST_IDLE;
            pre_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pre_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            dir_q   <= dir_d;
        end
    end

    assign running = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);

    bcd_digit_updown #(.MAX(DIGIT_MAX)) u_s0 (
        .clk    (clk),
        .rst    (rst),
        .clr    (clear),
        .ld     (digit_ld),
        .ld_val (s0_ld),
        .inc    (step_up),
        .dec    (step_dn),
        .q      (s0),
        .carry  (s0_carry),
        .borrow (s0_borrow)
    );

    bcd_digit_updown #(.MAX(SEC_TENS_MAX)) u_s1 (
        .clk    (clk),
        .rst    (rst),
        .clr    (clear),
        .ld     (digit_ld),
        .ld_val (s1_ld),
        .inc    (s0_carry),
        .dec    (s0_borrow),
        .q      (s1),
        .carry  (s1_carry),
        .borrow (s1_borrow)
    );

    bcd_digit_updown #(.MAX(DIGIT_MAX)) u_m0 (
        .clk    (clk),
        .rst    (rst),
        .clr    (clear),
        .ld     (digit_ld),
        .ld_val (m0_ld),
        .inc    (s1_carry),
        .dec    (s1_borrow),
        .q      (m0),
        .carry  (m0_carry),
        .borrow (m0_borrow)
    );

    bcd_digit_updown #(.MAX(MIN_TENS_MAX)) u_m1 (
        .clk    (clk),
        .rst    (rst),
        .clr    (clear),
        .ld     (digit_ld),
        .ld_val (m1_ld),
        .inc    (m0_carry),
        .dec    (m0_borrow),
        .q      (m1),
        .carry  (m1_carry),
        .borrow (m1_borrow)
    );

endmodule

// File: doc/crono_bcd_counter.md
Name: crono_bcd_counter

Overview:
- Time-keeping core of the stopwatch/timer. It produces four BCD digits in MM:SS form. Each digit drives one 7-segment decoder stage directly downstream.
- Up mode is a stopwatch; down mode is a countdown timer with a loadable preset.
- Contains a 1 Hz prescaler, a four-digit BCD up/down counter and a small control FSM.

Parameters:
- TICKS_PER_SEC, 50000000: clk cycles per counted second (benches use 4).
- PRE_W, 26: prescaler width; must satisfy 2^PRE_W >= TICKS_PER_SEC.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start_stop  input  1  single-cycle pulse; toggles run/pause.
- clear  input  1  single-cycle pulse; returns to IDLE at 00:00.
- load  input  1  single-cycle pulse; presets digits from load_* (IDLE only).
- mode_down  input  1  0 = count up (stopwatch), 1 = count down (timer); sampled only in IDLE.
- load_m1  input  4  preset minute tens, legal 0..5.
- load_m0  input  4  preset minute units, legal 0..9.
- load_s1  input  4  preset second tens, legal 0..5.
- load_s0  input  4  preset second units, legal 0..9.
- m1  output  4  minute tens digit (BCD).
- m0  output  4  minute units digit (BCD).
- s1  output  4  second tens digit (BCD).
- s0  output  4  second units digit (BCD).
- running  output  1  high in RUN.
- done  output  1  high in DONE.

Behaviour:
- Reset (async, rst=1): FSM=IDLE, prescaler=0, digits=0, running=0, done=0, latched direction=up. Reset mid-count abandons the count immediately.
- FSM states: IDLE, RUN, PAUSE, DONE.
  - IDLE: on start_stop -> RUN and latch mode_down. Exception: down mode with digits=00:00 ignores start_stop and stays IDLE.
  - RUN: on start_stop -> PAUSE. On a terminal step -> DONE.
  - PAUSE: on start_stop -> RUN. Prescaler and digits hold.
  - DONE: digits hold; only clear (or rst) exits, to IDLE.
- Priority within one cycle: clear > load > start_stop.
  - clear from any state: digits=0, prescaler=0, FSM=IDLE, the same cycle's start_stop is ignored.
- load: honoured only in IDLE; effective on the next edge.
  - Ignored if any load digit is out of range (m1>5, m0>9, s1>5, s0>9).
  - load together with start_stop in IDLE: load wins, FSM stays IDLE.
- Prescaler: counts only in RUN.
  - At TICKS_PER_SEC-1 it wraps to 0 and issues an internal one-cycle tick.
  - Holds in PAUSE; cleared on clear, load, and on the IDLE->RUN transition.
  - First tick therefore occurs exactly TICKS_PER_SEC cycles after the start_stop edge.
- Up step, on tick: s0 9->0 carries into s1; s1 5->0 carries into m0; m0 9->0 carries into m1.
  - At 59:59 the tick is terminal: digits stay 59:59 and FSM -> DONE in the same edge.
- Down step, on tick: s0 0->9 borrows from s1; s1 0->5 borrows from m0; m0 0->9 borrows from m1.
  - The tick that produces 00:00 is terminal: digits=00:00 and FSM -> DONE in the same edge.
- Digits are always legal BCD (s1,m1 <= 5; s0,m0 <= 9). They are registered outputs, one cycle after the causing edge.
- start_stop arriving in the same cycle as a terminal tick is ignored; DONE wins.
- mode_down changes outside IDLE have no effect.

Decomposition:
- Shared package crono_pkg holds:
  - state enum (ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE);
  - BCD digit typedef (4 bits);
  - constants SEC_TENS_MAX=5, MIN_TENS_MAX=5, DIGIT_MAX=9.
- One natural sub-module: bcd_digit_updown, a single BCD digit with parameterised max value, inc/dec enable, carry/borrow out and synchronous load/clear. Instantiated four times and chained.
- The prescaler and FSM stay in the top module.

Test Plan:
- Up count (TICKS_PER_SEC=4): rst, start_stop -> s0=1 after 4 cycles; after 60 ticks digits=01:00, running=1.
- Pause: run 10 ticks, start_stop, wait 20 cycles -> digits hold 00:10; start_stop -> next increment exactly 4 - elapsed_prescale cycles later.
- Countdown: load 00:02, mode_down=1, start_stop -> 00:01 after 4 cycles, 00:00 after 8, done=1, running=0; further start_stop no effect; clear -> done=0, IDLE.
- Up terminal: load 59:58, up mode, run -> 59:59 then DONE after the next tick; digits stay 59:59.
- Illegal load 06:0A ignored (digits unchanged). Load in RUN ignored. Down start at 00:00 stays IDLE.
- clear+start_stop same cycle in RUN -> IDLE at 00:00. Async rst mid-run -> outputs zero before the next clk edge.
